// File: rtl/qea_job_sequencer.sv
// rtl/qea_job_sequencer.sv - single-job sequencer driving the QEA core; optional QEA_SEQ_TIMEOUT_EN
// Loads context and state RAMs, starts QEA, times execution and streams the state vector back.
module qea_job_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = DATA_WIDTH*2,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH*2,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LAT                  = 1,
  parameter int CYC_WIDTH               = 32,
  parameter int TIMEOUT_CYC             = 1000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_job_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_num,
  input  logic                                 i_ctx_valid,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_ctx_ready,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_qea_ctx_en,
  output logic                                 o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
  output logic                                 o_qea_state_ena,
  output logic                                 o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_rd_valid,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic                                 o_rd_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [CYC_WIDTH-1:0]                 o_exec_cycles
);
  localparam int WORD_W = PE_NUM*STATE_DATA_WIDTH;
  localparam logic [STATE_DATA_WIDTH-1:0] ONE_AMP =
    {DATA_WIDTH'(64'd1 << NUM_FRAC_BIT), DATA_WIDTH'(0)};
  localparam logic [WORD_W-1:0] WORD0 = {ONE_AMP, {(WORD_W-STATE_DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CTX, S_LOAD_STATE, S_START, S_WAIT_CPL, S_READ, S_DRAIN
  } state_t;

  state_t r_state, w_next;

  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_cnt, r_ctx_last;
  logic [STATE_ADDR_WIDTH-1:0]        r_st_cnt, r_depth_m1, w_depth_m1;
  logic [MAX_QBIT_WIDTH-1:0]          w_shamt;
  logic [CYC_WIDTH-1:0]               r_cyc;
  logic                               r_first, r_rd_tag;
  logic [RD_LAT-1:0]                  r_vpipe, r_lpipe;

  logic w_job_ok, w_beat, w_ctx_end, w_st_end, w_cpl, w_timeout, w_drain_end;

  logic                               w_ctx_en, w_st_ena, w_st_wea, w_start, w_rd_tag;
  logic                               w_done, w_busy, w_error;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] w_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] w_ctx_data;
  logic [STATE_ADDR_WIDTH-1:0]        w_st_addr;
  logic [WORD_W-1:0]                  w_st_dina;
  logic [CYC_WIDTH-1:0]               w_exec;
  logic [MAX_QBIT_WIDTH-1:0]          w_qbit;

  assign w_job_ok    = (i_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) && (i_ctx_num != '0);
  assign w_shamt     = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign w_depth_m1  = (STATE_ADDR_WIDTH'(1) << w_shamt) - STATE_ADDR_WIDTH'(1);
  assign w_beat      = (r_state == S_LOAD_CTX) && i_ctx_valid;
  assign w_ctx_end   = w_beat && (r_ctx_cnt == r_ctx_last);
  assign w_st_end    = (r_st_cnt == r_depth_m1);
  assign w_cpl       = i_qea_complete && !r_first;
  assign w_drain_end = r_lpipe[RD_LAT-1];

`ifdef QEA_SEQ_TIMEOUT_EN
  assign w_timeout = (r_cyc >= CYC_WIDTH'(TIMEOUT_CYC));
`else
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (i_job_start && w_job_ok) w_next = S_LOAD_CTX;
      S_LOAD_CTX:   if (w_ctx_end) w_next = S_LOAD_STATE;
      S_LOAD_STATE: if (w_st_end) w_next = S_START;
      S_START:      w_next = S_WAIT_CPL;
      S_WAIT_CPL:   if (w_cpl) w_next = S_READ;
                    else if (w_timeout) w_next = S_IDLE;
      S_READ:       if (w_st_end) w_next = S_DRAIN;
      S_DRAIN:      if (w_drain_end) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; strobes default low, status holds.
  always_comb begin
    w_ctx_en   = 1'b0;
    w_ctx_addr = '0;
    w_ctx_data = '0;
    w_st_ena   = 1'b0;
    w_st_wea   = 1'b0;
    w_st_addr  = '0;
    w_st_dina  = '0;
    w_start    = 1'b0;
    w_rd_tag   = 1'b0;
    w_done     = 1'b0;
    w_busy     = o_busy;
    w_error    = o_error;
    w_exec     = o_exec_cycles;
    w_qbit     = o_qea_qbit_num;
    case (r_state)
      S_IDLE: if (i_job_start) begin
        w_qbit = i_qbit_num;
        if (w_job_ok) begin
          w_busy  = 1'b1;
          w_error = 1'b0;
        end else begin
          w_error = 1'b1;
          w_done  = 1'b1;
        end
      end
      S_LOAD_CTX: if (w_beat) begin
        w_ctx_en   = 1'b1;
        w_ctx_addr = r_ctx_cnt;
        w_ctx_data = i_ctx_data;
      end
      S_LOAD_STATE: begin
        w_st_ena  = 1'b1;
        w_st_wea  = 1'b1;
        w_st_addr = r_st_cnt;
        w_st_dina = (r_st_cnt == '0) ? WORD0 : '0;
      end
      S_START: w_start = 1'b1;
      S_WAIT_CPL: begin
        if (w_cpl) begin
          w_exec = r_cyc;
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_exec  = '1;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end
      end
      S_READ: begin
        w_st_ena  = 1'b1;
        w_st_addr = r_st_cnt;
        w_rd_tag  = w_st_end;
      end
      S_DRAIN: if (w_drain_end) begin
        w_done = 1'b1;
        w_busy = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_qea_ctx_en      <= 1'b0;
      o_qea_ctx_wea     <= 1'b0;
      o_qea_ctx_addr    <= '0;
      o_qea_ctx_data    <= '0;
      o_qea_state_ena   <= 1'b0;
      o_qea_state_wea   <= 1'b0;
      o_qea_state_addra <= '0;
      o_qea_state_dina  <= '0;
      o_qea_start       <= 1'b0;
      o_qea_qbit_num    <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_error           <= 1'b0;
      o_exec_cycles     <= '0;
      r_rd_tag          <= 1'b0;
      r_vpipe           <= '0;
      r_lpipe           <= '0;
    end else begin
      o_qea_ctx_en      <= w_ctx_en;
      o_qea_ctx_wea     <= w_ctx_en;
      o_qea_ctx_addr    <= w_ctx_addr;
      o_qea_ctx_data    <= w_ctx_data;
      o_qea_state_ena   <= w_st_ena;
      o_qea_state_wea   <= w_st_wea;
      o_qea_state_addra <= w_st_addr;
      o_qea_state_dina  <= w_st_dina;
      o_qea_start       <= w_start;
      o_qea_qbit_num    <= w_qbit;
      o_busy            <= w_busy;
      o_done            <= w_done;
      o_error           <= w_error;
      o_exec_cycles     <= w_exec;
      r_rd_tag          <= w_rd_tag;
      // Read strobe as seen by QEA, delayed to match its read latency.
      r_vpipe[0]        <= o_qea_state_ena & ~o_qea_state_wea;
      r_lpipe[0]        <= r_rd_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctx_cnt  <= '0;
      r_ctx_last <= '0;
      r_st_cnt   <= '0;
      r_depth_m1 <= '0;
      r_cyc      <= '0;
      r_first    <= 1'b0;
    end else begin
      r_first <= (r_state == S_START);
      if (r_state == S_IDLE && i_job_start) begin
        r_ctx_cnt  <= '0;
        r_ctx_last <= i_ctx_num - GATE_CONTEXT_ADDR_WIDTH'(1);
        r_st_cnt   <= '0;
        r_depth_m1 <= w_depth_m1;
      end
      if (w_beat) r_ctx_cnt <= r_ctx_cnt + GATE_CONTEXT_ADDR_WIDTH'(1);
      if (r_state == S_LOAD_STATE || r_state == S_READ)
        r_st_cnt <= w_st_end ? '0 : r_st_cnt + STATE_ADDR_WIDTH'(1);
      // Counter reads 1 in the cycle the start pulse is visible to QEA.
      if (r_state == S_START)
        r_cyc <= CYC_WIDTH'(1);
      else if (r_state == S_WAIT_CPL && !(&r_cyc))
        r_cyc <= r_cyc + CYC_WIDTH'(1);
    end
  end

  assign o_ctx_ready = (r_state == S_LOAD_CTX);
  assign o_rd_valid  = r_vpipe[RD_LAT-1];
  assign o_rd_last   = r_lpipe[RD_LAT-1];
  assign o_rd_data   = o_rd_valid ? i_qea_state_dout : '0;

endmodule

// File: doc/qea_job_sequencer.md
Name: qea_job_sequencer

Overview:
Hardware replacement for host-side bring-up sequencing of the QEA core. It accepts one job at a time and runs it in order:
- streams gate-context words into QEA context RAM;
- initialises state RAM to basis state |0...0>;
- pulses start, waits for completion and counts execution cycles;
- streams the final state vector back out.
It sits between the host/DMA interface and the QEA top level and is QEA's only driver.

Parameters:
PE_NUM_WIDTH, 2, log2 of PE count
PE_NUM, 4, PEs (state slices per RAM word)
DATA_WIDTH, 32, real/imag component width
MAX_QBIT_WIDTH, 6, width of qubit-count fields
STATE_DATA_WIDTH, DATA_WIDTH*2, one complex amplitude {real,imag}
STATE_ADDR_WIDTH, 16, state RAM address width
GATE_CONTEXT_DATA_WIDTH, DATA_WIDTH*2, context word width
GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
NUM_FRAC_BIT, 30, fixed-point fraction bits (1.0 = 2^NUM_FRAC_BIT)
RD_LAT, 1, QEA state-read latency in cycles (1..4)
CYC_WIDTH, 32, execution-cycle counter width
TIMEOUT_CYC, 1000000, completion timeout (only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_job_start  in  1  one-cycle job request; ignored unless idle
i_qbit_num  in  MAX_QBIT_WIDTH  qubits for the job
i_ctx_num  in  GATE_CONTEXT_ADDR_WIDTH  context words to load
i_ctx_valid  in  1  context stream valid
i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context stream data
o_ctx_ready  out  1  context stream ready
o_qea_start  out  1  QEA start pulse
o_qea_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count
o_qea_ctx_en, o_qea_ctx_wea  out  1  context RAM enable / write
o_qea_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context address
o_qea_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context data
o_qea_state_ena, o_qea_state_wea  out  1  state RAM enable / write
o_qea_state_addra  out  STATE_ADDR_WIDTH  state address
o_qea_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state write data
i_qea_complete  in  1  QEA completion level
i_qea_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state read data
o_rd_valid  out  1  readout word valid
o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  readout word
o_rd_last  out  1  last readout word
o_busy  out  1  job in progress
o_done  out  1  one-cycle job-finished pulse
o_error  out  1  sticky error; cleared by next accepted job
o_exec_cycles  out  CYC_WIDTH  cycles of last execution

Behaviour:
- Reset: all outputs 0; o_qea_qbit_num = 0; state = IDLE.
- Register all QEA-side outputs.
- Derived depth: D = 2^(qbit_num - PE_NUM_WIDTH) state words.
- IDLE:
  - On i_job_start, latch qbit_num and ctx_num, clear o_error, set o_busy.
  - If qbit_num < PE_NUM_WIDTH or ctx_num == 0: o_error = 1, o_done pulse, stay IDLE.
  - Otherwise go to LOAD_CTX.
- LOAD_CTX:
  - o_ctx_ready = 1.
  - Each valid&ready beat writes one word: ctx_en = wea = 1, addresses 0..ctx_num-1 ascending.
  - No beat means no write; stalls are unbounded.
  - After the beat with address ctx_num-1, go to LOAD_STATE (ready drops the next cycle).
- LOAD_STATE:
  - D consecutive cycles, ena = wea = 1, addr 0..D-1.
  - Word 0: top slice [PE_NUM*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] has real = 2^NUM_FRAC_BIT, imag = 0; all other slices 0.
  - All other words 0.
- START: o_qea_start = 1 for exactly one cycle; the cycle counter is loaded with 1.
- WAIT_CPL:
  - The counter increments every cycle.
  - i_qea_complete is ignored in the first WAIT_CPL cycle.
  - From the second cycle, the first cycle with complete = 1 latches the counter into o_exec_cycles and moves to READ.
  - The counter saturates at all-ones.
- READ:
  - D cycles, ena = 1, wea = 0, addr 0..D-1.
  - o_rd_valid follows each address by RD_LAT cycles, with o_rd_data = i_qea_state_dout.
  - o_rd_last accompanies word D-1.
  - There is no backpressure; the consumer must accept every cycle.
- DRAIN:
  - Wait until the final valid has issued, then pulse o_done and clear o_busy in the same cycle.
  - Return to IDLE.
- A job start while busy is ignored.
- A reset mid-job aborts immediately; the QEA sees start/ena/wea = 0 on the next edge.

Optional Feature:
Macro QEA_SEQ_TIMEOUT_EN.
- Defined: if WAIT_CPL lasts TIMEOUT_CYC cycles without complete:
  - set o_error;
  - o_exec_cycles = all-ones;
  - skip READ, pulse o_done, return to IDLE.
- Undefined: wait indefinitely; the timeout logic and TIMEOUT_CYC have no effect.

Test Plan:
1. qbit_num = 3, ctx_num = 57, continuous valid -> 57 context writes at addr 0..56 in 57 cycles; state writes addr 0,1; word0 = 64'h40000000_00000000 in top slice, word1 = 0.
2. ctx stream with valid toggling every other cycle -> addresses contiguous with no gaps or repeats; LOAD_STATE starts only after word 56.
3. complete asserted 10 cycles after the start pulse -> o_exec_cycles = 11; with RD_LAT = 2, rd_valid appears 2 cycles after each read address; rd_last on word 1; o_done is 1 cycle.
4. qbit_num = 1 -> o_error = 1, o_done pulse, no QEA strobes; i_job_start during a running job -> ignored.
5. rst asserted during LOAD_CTX -> all outputs 0 asynchronously; a new job afterwards starts at ctx addr 0.
6. With QEA_SEQ_TIMEOUT_EN and TIMEOUT_CYC = 100, complete never asserted -> o_error = 1, o_exec_cycles = all-ones, no rd_valid, o_done pulse.
